fp_addsub_seq: RTL and testbench

- Parametrised multi-cycle IEEE-754-style floating-point adder/subtractor.
- Successor to the fixed 32-bit addition stage. Generalised in exponent and mantissa width.
- Adds a fixed-latency load/ready handshake, round-to-nearest-even, special-value handling and status flags.
- Sits in the calculator datapath between the operand registers and the result/display stage.

---
 rtl/fp_addsub_seq.sv | 200 ++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_addsub_seq : multi-cycle parametrised FP add/sub, RNE, DAZ/FTZ, flags   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 load,
    input  logic                 op,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 ready,
    output logic [3:0]           flags
);
    localparam int c_W   = 1 + EXP_W + MAN_W;
    localparam int c_MW  = MAN_W + 4;
    localparam int c_SW  = MAN_W + 5;
    localparam int c_EW  = EXP_W + 2;
    localparam int c_LZW = $clog2(c_MW);
    localparam logic signed [c_EW-1:0] c_EMAX = c_EW'((2 ** EXP_W) - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_UNPACK = 3'd1;
    localparam logic [2:0] c_ALIGN  = 3'd2;
    localparam logic [2:0] c_ADDSUB = 3'd3;
    localparam logic [2:0] c_NORM   = 3'd4;
    localparam logic [2:0] c_ROUND  = 3'd5;
    localparam logic [2:0] c_DONE   = 3'd6;

    logic [2:0]              state_q, state_d;
    logic [c_W-1:0]          a_q, b_q, result_q, w_res;
    logic                    op_q, sa_q, sb_q, nan_q, infa_q, infb_q, za_q, zb_q;
    logic [EXP_W-1:0]        ea_q, eb_q, xe_q;
    logic [MAN_W:0]          ma_q, mb_q;
    logic                    xs_q, sub_q, nz_q;
    logic [c_MW-1:0]         xm_q, ym_q, nm_q;
    logic [c_SW-1:0]         sum_q;
    logic signed [c_EW-1:0]  ne_q;
    logic [3:0]              flags_q, w_flg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    state_q <= c_IDLE;
        else if (en) state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE, c_DONE: if (load) state_d = c_UNPACK;
            c_UNPACK:       state_d = c_ALIGN;
            c_ALIGN:        state_d = c_ADDSUB;
            c_ADDSUB:       state_d = c_NORM;
            c_NORM:         state_d = c_ROUND;
            c_ROUND:        state_d = c_DONE;
            default:        state_d = c_IDLE;
        endcase
    end

    always_comb begin
        ready  = (state_q == c_DONE);
        result = result_q;
        flags  = flags_q;
    end

    // Operand classification; a zero exponent field flushes the operand to zero
    logic [EXP_W-1:0] w_ea, w_eb;
    logic             w_nan_a, w_nan_b;
    assign w_ea    = a_q[c_W-2:MAN_W];
    assign w_eb    = b_q[c_W-2:MAN_W];
    assign w_nan_a = (&w_ea) & (|a_q[MAN_W-1:0]);
    assign w_nan_b = (&w_eb) & (|b_q[MAN_W-1:0]);

    logic             w_swap;
    logic [EXP_W-1:0] w_ex, w_ey, w_diff;
    logic [MAN_W:0]   w_mx, w_my;
    logic [c_MW-1:0]  w_yext, w_ysh, w_mask;
    assign w_swap = {eb_q, mb_q} > {ea_q, ma_q};
    assign w_ex   = w_swap ? eb_q : ea_q;
    assign w_ey   = w_swap ? ea_q : eb_q;
    assign w_mx   = w_swap ? mb_q : ma_q;
    assign w_my   = w_swap ? ma_q : mb_q;
    assign w_diff = w_ex - w_ey;
    assign w_yext = {w_my, 3'b000};

    always_comb begin
        w_ysh  = '0;
        w_mask = '0;
        if (int'(w_diff) >= MAN_W + 3) begin
            w_ysh[0] = |w_my;
        end else begin
            w_mask   = (c_MW'(1) << w_diff) - c_MW'(1);
            w_ysh    = w_yext >> w_diff;
            w_ysh[0] = w_ysh[0] | (|(w_yext & w_mask));
        end
    end

    logic [c_LZW-1:0] w_lz;
    always_comb begin
        w_lz = '0;
        for (int i = 0; i < c_MW; i++)
            if (sum_q[i]) w_lz = c_LZW'(c_MW - 1 - i);
    end

    always_ff @(posedge clk) begin
        if (en) begin
            case (state_q)
                c_IDLE, c_DONE: if (load) begin
                    a_q  <= a;
                    b_q  <= b;
                    op_q <= op;
                end
                c_UNPACK: begin
                    sa_q   <= a_q[c_W-1];
                    sb_q   <= b_q[c_W-1] ^ op_q;
                    ea_q   <= w_ea;
                    eb_q   <= w_eb;
                    ma_q   <= (w_ea == '0) ? '0 : {1'b1, a_q[MAN_W-1:0]};
                    mb_q   <= (w_eb == '0) ? '0 : {1'b1, b_q[MAN_W-1:0]};
                    nan_q  <= w_nan_a | w_nan_b;
                    infa_q <= (&w_ea) & ~(|a_q[MAN_W-1:0]);
                    infb_q <= (&w_eb) & ~(|b_q[MAN_W-1:0]);
                    za_q   <= (w_ea == '0);
                    zb_q   <= (w_eb == '0);
                end
                c_ALIGN: begin
                    xs_q  <= w_swap ? sb_q : sa_q;
                    xe_q  <= w_ex;
                    xm_q  <= {w_mx, 3'b000};
                    ym_q  <= w_ysh;
                    sub_q <= sa_q ^ sb_q;
                end
                c_ADDSUB: sum_q <= sub_q ? ({1'b0, xm_q} - {1'b0, ym_q})
                                         : ({1'b0, xm_q} + {1'b0, ym_q});
                c_NORM: begin
                    nz_q <= (sum_q == '0);
                    if (sum_q[c_SW-1]) begin
                        nm_q <= {sum_q[c_SW-1:2], sum_q[1] | sum_q[0]};
                        ne_q <= {2'b00, xe_q} + c_EW'(1);
                    end else begin
                        nm_q <= sum_q[c_MW-1:0] << w_lz;
                        ne_q <= {2'b00, xe_q} - c_EW'(w_lz);
                    end
                end
                default: ;
            endcase
        end
    end

    logic                   w_g, w_r, w_s, w_inc;
    logic [MAN_W+1:0]       w_rm;
    logic [MAN_W-1:0]       w_frac;
    logic signed [c_EW-1:0] w_fe;
    assign w_g    = nm_q[2];
    assign w_r    = nm_q[1];
    assign w_s    = nm_q[0];
    assign w_inc  = w_g & (w_r | w_s | nm_q[3]);
    assign w_rm   = {1'b0, nm_q[c_MW-1:3]} + (MAN_W + 2)'(w_inc);
    assign w_fe   = ne_q + c_EW'(w_rm[MAN_W+1]);
    assign w_frac = w_rm[MAN_W+1] ? w_rm[MAN_W:1] : w_rm[MAN_W-1:0];

    // Special operands take precedence over the arithmetic path
    always_comb begin
        w_res = '0;
        w_flg = '0;
        if (nan_q || (infa_q && infb_q && (sa_q != sb_q))) begin
            w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            w_flg = 4'b1000;
        end else if (infa_q || infb_q) begin
            w_res = {infa_q ? sa_q : sb_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (nz_q) begin
            w_res = {za_q & zb_q & sa_q & sb_q, {(c_W-1){1'b0}}};
        end else if (w_fe >= c_EMAX) begin
            w_res = {xs_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flg = 4'b0101;
        end else if (w_fe[c_EW-1] || (w_fe == '0)) begin
            w_res = {xs_q, {(c_W-1){1'b0}}};
            w_flg = 4'b0011;
        end else begin
            w_res = {xs_q, w_fe[EXP_W-1:0], w_frac};
            w_flg = {3'b000, w_g | w_r | w_s};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
            flags_q  <= '0;
        end else if (en && (state_q == c_ROUND)) begin
            result_q <= w_res;
            flags_q  <= w_flg;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fp_addsub_seq : scoreboard bench for single and half-width configs      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_fp_addsub_seq;
    localparam int P = 10;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
        time         t0;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b0, en = 1'b1;
    logic        ld32 = 1'b0, op32 = 1'b0, rdy32;
    logic [31:0] a32 = '0, b32 = '0, res32;
    logic [3:0]  fl32;
    logic        ld16 = 1'b0, op16 = 1'b0, rdy16;
    logic [15:0] a16 = '0, b16 = '0, res16;
    logic [3:0]  fl16;

    exp_t q32[$], q16[$];
    exp_t e32, e16;
    logic p32 = 1'b0, p16 = 1'b0;
    int   n_tests = 0, n_fail = 0;

    fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) u_dut32 (
        .clk(clk), .rst(rst), .en(en), .load(ld32), .op(op32), .a(a32), .b(b32),
        .result(res32), .ready(rdy32), .flags(fl32)
    );

    fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) u_dut16 (
        .clk(clk), .rst(rst), .en(en), .load(ld16), .op(op16), .a(a16), .b(b16),
        .result(res16), .ready(rdy16), .flags(fl16)
    );

    always #(P/2) clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each rising edge of ready retires one scoreboard entry
    always @(negedge clk) begin
        if (rdy32 && !p32) begin
            if (q32.size() == 0) chk("ready32_spurious", 64'(rdy32), 64'd0);
            else begin
                e32 = q32.pop_front();
                chk("result32", 64'(res32), 64'(e32.res));
                chk("flags32", 64'(fl32), 64'(e32.fl));
                chk("latency32", 64'(($time - e32.t0 - P/2) / P), 64'(e32.lat));
            end
        end
        p32 = rdy32;
        if (rdy16 && !p16) begin
            if (q16.size() == 0) chk("ready16_spurious", 64'(rdy16), 64'd0);
            else begin
                e16 = q16.pop_front();
                chk("result16", 64'(res16), 64'(e16.res));
                chk("flags16", 64'(fl16), 64'(e16.fl));
                chk("latency16", 64'(($time - e16.t0 - P/2) / P), 64'(e16.lat));
            end
        end
        p16 = rdy16;
    end

    task automatic go32(input logic [31:0] a, input logic [31:0] b, input logic op,
                        input logic [31:0] r, input logic [3:0] f, input int lat);
        exp_t e;
        @(negedge clk);
        a32 = a; b32 = b; op32 = op; ld32 = 1'b1;
        @(posedge clk);
        e.res = r; e.fl = f; e.lat = lat; e.t0 = $time;
        q32.push_back(e);
        @(negedge clk);
        ld32 = 1'b0;
    endtask

    task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic op,
                        input logic [15:0] r, input logic [3:0] f);
        exp_t e;
        @(negedge clk);
        a16 = a; b16 = b; op16 = op; ld16 = 1'b1;
        @(posedge clk);
        e.res = {16'h0, r}; e.fl = f; e.lat = 5; e.t0 = $time;
        q16.push_back(e);
        @(negedge clk);
        ld16 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q16.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(q32.size() + q16.size()), 64'd0);
        q32.delete();
        q16.delete();
        @(negedge clk);
    endtask

    initial begin
        #2;
        chk("reset_ready32", 64'(rdy32), 64'd0);
        chk("reset_result32", 64'(res32), 64'd0);
        chk("reset_flags32", 64'(fl32), 64'd0);
        chk("reset_ready16", 64'(rdy16), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        go32(32'h40D80000, 32'h40400000, 1'b0, 32'h411C0000, 4'b0000, 5); drain();
        go32(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'b0000, 5); drain();
        go32(32'h40A00000, 32'h40000000, 1'b1, 32'h40400000, 4'b0000, 5); drain();
        go32(32'h4B000000, 32'h3F800000, 1'b0, 32'h4B000001, 4'b0000, 5); drain();
        go32(32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 4'b0001, 5); drain();
        go32(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000, 5); drain();
        go32(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 5); drain();
        go32(32'h00400000, 32'h3F000000, 1'b0, 32'h3F000000, 4'b0000, 5); drain();
        go32(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 5); drain();
        go32(32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 4'b0000, 5); drain();
        go32(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000, 5); drain();
        go32(32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 4'b0011, 5); drain();
        go16(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000); drain();
        go16(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101); drain();

        // Three disabled cycles stretch the latency to eight edges
        go32(32'h40D80000, 32'h40400000, 1'b0, 32'h411C0000, 4'b0000, 8);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        drain();

        // A load while busy must not disturb the captured operands
        go32(32'h40A00000, 32'h40000000, 1'b1, 32'h40400000, 4'b0000, 5);
        a32 = 32'h7F800000; b32 = 32'hFF800000; op32 = 1'b0; ld32 = 1'b1;
        @(negedge clk);
        ld32 = 1'b0;
        drain();

        // Abort mid-operation with reset
        a32 = 32'h3F800000; b32 = 32'h3F800000; op32 = 1'b0; ld32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ld32 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_ready", 64'(rdy32), 64'd0);
        chk("abort_result", 64'(res32), 64'd0);
        chk("abort_flags", 64'(fl32), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_idle_ready", 64'(rdy32), 64'd0);
        go32(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 5); drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
